// File: rtl/axibram_read_wide_pkg.sv
// axibram_pkg: shared burst/response codes, engine states and burst address stepping
// Exports: BURST_* and RESP_* codes, state_t, wrap_ok(), burst_err(), next_addr()
package axibram_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic logic wrap_ok(logic [3:0] len);
    return len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15;
  endfunction
  function automatic logic burst_err(logic [1:0] burst, logic [3:0] len);
    return burst == 2'b11 || (burst == BURST_WRAP && !wrap_ok(len));
  endfunction
  // Reserved bursts and illegal-length WRAPs step like INCR.
  function automatic logic [31:0] next_addr(logic [31:0] addr, logic [1:0] burst, logic [3:0] len);
    return burst == BURST_FIXED ? addr :
           burst == BURST_WRAP && wrap_ok(len) ? (addr & ~{28'd0, len}) | ((addr + 32'd1) & {28'd0, len}) :
           addr + 32'd1;
  endfunction
endpackage

// File: rtl/axibram_read_wide_if.sv
// axibram_read_wide_if: AXI3 read channels (AR + R) between a GP master and the BRAM bridge
// Modports: master drives AR payload/arvalid and rready; slave drives arready and the R beat
interface axibram_read_wide_if #(parameter int DATA_BITS = 32, parameter int ID_BITS = 12);
  logic [31:0] araddr;
  logic arvalid;
  logic arready;
  logic [ID_BITS-1:0] arid;
  logic [3:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [DATA_BITS-1:0] rdata;
  logic rvalid;
  logic rready;
  logic [ID_BITS-1:0] rid;
  logic rlast;
  logic [1:0] rresp;
  modport master(output araddr, arvalid, arid, arlen, arsize, arburst, rready,
                 input arready, rdata, rvalid, rid, rlast, rresp);
  modport slave(input araddr, arvalid, arid, arlen, arsize, arburst, rready,
                output arready, rdata, rvalid, rid, rlast, rresp);
endinterface

// File: rtl/axibram_read_wide_fifo.sv
// fifo_sync_w_d: synchronous FIFO, 2**DEPTH_LOG2 entries, push and pop allowed together when full
// Ports: aclk, rst (async, active-high), push/din, pop/dout (head), nempty, full, count
module fifo_sync_w_d #(parameter int WIDTH = 8, parameter int DEPTH_LOG2 = 2) (
  input  logic aclk,
  input  logic rst,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic nempty,
  output logic full,
  output logic [DEPTH_LOG2:0] count
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && nempty;
  assign do_push = push && (!full || do_pop);
  assign nempty = count != '0;
  assign full = count[DEPTH_LOG2];
  assign dout = mem[rp];
  always_ff @(posedge aclk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + DEPTH_LOG2'(do_push);
      rp <= rp + DEPTH_LOG2'(do_pop);
      count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
  always_ff @(posedge aclk) if (do_push) mem[wp] <= din;
endmodule

// File: rtl/axibram_read_wide.sv
// axibram_read_wide: AXI3 read slave (FIXED/INCR/WRAP) bridging to a synchronous BRAM read port
// Ports: aclk, rst (async, active-high); axi (slave modport: AR in, R out);
//        bram_rclk/bram_raddr/bram_ren/bram_regen out, bram_rdata in
module axibram_read_wide import axibram_pkg::*; #(
  parameter int DATA_BITS = 32,
  parameter int ADDRESS_BITS = 10,
  parameter int ID_BITS = 12,
  parameter int AR_DEPTH_LOG2 = 2,
  parameter int BRAM_LATENCY = 2
) (
  input  logic aclk,
  input  logic rst,
  axibram_read_wide_if.slave axi,
  output logic bram_rclk,
  output logic [ADDRESS_BITS-1:0] bram_raddr,
  output logic bram_ren,
  output logic bram_regen,
  input  logic [DATA_BITS-1:0] bram_rdata
);
  localparam int S = $clog2(DATA_BITS/8);
  localparam int R_DEPTH = BRAM_LATENCY + 2;
  localparam int AF_W = ID_BITS + 2 + 3 + 4 + ADDRESS_BITS;
  localparam int MW = ID_BITS + 3;
  localparam int OF_W = MW + DATA_BITS;
  localparam int OF_LOG2 = $clog2(R_DEPTH);
  function automatic logic [ADDRESS_BITS-1:0] step(logic [ADDRESS_BITS-1:0] a, logic [1:0] b, logic [3:0] l);
    return ADDRESS_BITS'(next_addr(32'(a), b, l));
  endfunction
  logic up, af_pop, af_nempty, af_full, of_nempty, of_full, credit, arrive, regen_q, unused_ok;
  logic [AF_W-1:0] af_dout;
  logic [AR_DEPTH_LOG2:0] af_count;
  logic [OF_W-1:0] of_dout;
  logic [OF_LOG2:0] of_count;
  logic [ID_BITS-1:0] h_id, id, id_n, iid;
  logic [1:0] h_burst, burst, burst_n;
  logic [2:0] h_size;
  logic [3:0] h_len, len, len_n, cnt, cnt_n;
  logic [ADDRESS_BITS-1:0] h_addr, addr, addr_n, iaddr, raddr_q;
  logic h_err, err, err_n, ierr, ilast;
  logic [MW-1:0] imeta;
  logic [BRAM_LATENCY-1:0] pv;
  logic [BRAM_LATENCY-1:0][MW-1:0] pm;
  state_t state, state_n;
  assign unused_ok = ^{af_count, of_full, axi.araddr};
  // A pop on a full address FIFO frees the slot the incoming AR needs.
  assign axi.arready = up && (!af_full || af_pop);
  fifo_sync_w_d #(.WIDTH(AF_W), .DEPTH_LOG2(AR_DEPTH_LOG2)) u_ar (
    .aclk, .rst, .push(axi.arvalid && axi.arready),
    .din({axi.arid, axi.arburst, axi.arsize, axi.arlen, axi.araddr[ADDRESS_BITS+S-1:S]}),
    .pop(af_pop), .dout(af_dout), .nempty(af_nempty), .full(af_full), .count(af_count));
  assign {h_id, h_burst, h_size, h_len, h_addr} = af_dout;
  assign h_err = burst_err(h_burst, h_len) || h_size != 3'(S);
  // Reads already in the BRAM pipeline are counted so the output FIFO can always absorb them.
  assign credit = int'(of_count) + $countones(pv) < R_DEPTH;
  // In IDLE the first beat is issued straight from the FIFO head; in BURST cnt is beats left minus one.
  always_comb begin
    state_n = state;
    {id_n, burst_n, len_n, err_n, addr_n, cnt_n} = {id, burst, len, err, addr, cnt};
    bram_ren = 1'b0;
    af_pop = 1'b0;
    {iid, ierr, iaddr, ilast} = {id, err, addr, 1'b0};
    if (state == IDLE) begin
      if (af_nempty && credit) begin
        bram_ren = 1'b1;
        af_pop = 1'b1;
        {iid, ierr, iaddr, ilast} = {h_id, h_err, h_addr, h_len == 4'd0};
        {id_n, burst_n, len_n, err_n} = {h_id, h_burst, h_len, h_err};
        addr_n = step(h_addr, h_burst, h_len);
        cnt_n = h_len - 4'd1;
        state_n = h_len == 4'd0 ? IDLE : BURST;
      end
    end else if (credit) begin
      bram_ren = 1'b1;
      ilast = cnt == 4'd0;
      if (cnt != 4'd0) begin
        cnt_n = cnt - 4'd1;
        addr_n = step(addr, burst, len);
      end else begin
        af_pop = af_nempty;
        state_n = af_nempty ? BURST : IDLE;
        {id_n, burst_n, len_n, err_n, addr_n, cnt_n} = {h_id, h_burst, h_len, h_err, h_addr, h_len};
      end
    end
  end
  assign imeta = {iid, ierr ? RESP_SLVERR : RESP_OKAY, ilast};
  always_ff @(posedge aclk or posedge rst)
    if (rst) begin
      state <= IDLE;
      up <= 1'b0;
      raddr_q <= '0;
      regen_q <= 1'b0;
      pv <= '0;
    end else begin
      state <= state_n;
      up <= 1'b1;
      raddr_q <= bram_ren ? iaddr : raddr_q;
      regen_q <= bram_ren;
      pv <= BRAM_LATENCY'({pv, bram_ren});
    end
  always_ff @(posedge aclk) begin
    {id, burst, len, err, addr, cnt} <= {id_n, burst_n, len_n, err_n, addr_n, cnt_n};
    pm <= (BRAM_LATENCY*MW)'({pm, imeta});
  end
  assign bram_rclk = aclk;
  assign bram_raddr = bram_ren ? iaddr : raddr_q;
  assign bram_regen = BRAM_LATENCY == 2 && regen_q;
  // Arriving data is presented directly when the FIFO is empty, giving rvalid
  // in the same cycle the BRAM data appears; it is stored only if not taken.
  assign arrive = pv[BRAM_LATENCY-1];
  fifo_sync_w_d #(.WIDTH(OF_W), .DEPTH_LOG2(OF_LOG2)) u_r (
    .aclk, .rst, .push(arrive && (of_nempty || !axi.rready)),
    .din({pm[BRAM_LATENCY-1], bram_rdata}),
    .pop(axi.rready), .dout(of_dout), .nempty(of_nempty), .full(of_full), .count(of_count));
  assign axi.rvalid = of_nempty || arrive;
  assign {axi.rid, axi.rresp, axi.rlast, axi.rdata} =
    of_nempty ? of_dout : arrive ? {pm[BRAM_LATENCY-1], bram_rdata} : '0;
endmodule

// File: tb/tb_axibram_read_wide.sv
// tb_axibram_read_wide: randomized scoreboard bench for axibram_read_wide with a BRAM model
module tb_axibram_read_wide;
  localparam int DW = 32, AW = 10, IW = 12, L = 2;
  typedef struct {logic [DW-1:0] data; logic [IW-1:0] id; logic [1:0] resp; logic last;} beat_t;
  logic aclk = 1'b0, rst = 1'b1;
  logic bram_rclk, bram_ren, bram_regen;
  logic [AW-1:0] bram_raddr;
  logic [DW-1:0] bram_rdata, lat, oreg;
  logic [DW-1:0] mem [1<<AW];
  int checks = 0, failures = 0, cyc = 0;
  int ren_count = 0, first_ren = -1, first_rv = -1, beats_seen = 0;
  beat_t exp_q[$];
  int addr_q[$];
  int beat_cyc[$];
  logic rr_rand = 1'b0, rr_val = 1'b1;
  logic hold = 1'b0, prev_ren = 1'b0;
  logic [DW+IW+2:0] held;
  beat_t mon_e;

  axibram_read_wide_if #(.DATA_BITS(DW), .ID_BITS(IW)) axi ();
  axibram_read_wide #(.DATA_BITS(DW), .ADDRESS_BITS(AW), .ID_BITS(IW), .AR_DEPTH_LOG2(2), .BRAM_LATENCY(L)) dut (
    .aclk(aclk), .rst(rst), .axi(axi), .bram_rclk(bram_rclk), .bram_raddr(bram_raddr),
    .bram_ren(bram_ren), .bram_regen(bram_regen), .bram_rdata(bram_rdata));

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    if (bram_ren) lat <= mem[bram_raddr];
    if (bram_regen) oreg <= lat;
  end
  assign bram_rdata = L == 2 ? oreg : lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    axi.rready = 1'b1;
    forever begin
      @(posedge aclk);
      #1 axi.rready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
    end
  end

  always @(negedge aclk) begin
    if (rst) begin
      hold = 1'b0;
      prev_ren = 1'b0;
    end else begin
      if (bram_ren || bram_regen) check("regen", bram_regen, prev_ren);
      prev_ren = bram_ren;
      if (bram_ren) begin
        ren_count++;
        if (first_ren < 0) first_ren = cyc;
        check("raddr_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) check("raddr", bram_raddr, addr_q.pop_front());
      end
      if (axi.rvalid && first_rv < 0) first_rv = cyc;
      if (hold) check("r_stable", {axi.rvalid, axi.rdata, axi.rid, axi.rresp, axi.rlast}, {1'b1, held});
      hold = axi.rvalid && !axi.rready;
      held = {axi.rdata, axi.rid, axi.rresp, axi.rlast};
      if (axi.rvalid && axi.rready) begin
        beats_seen++;
        beat_cyc.push_back(cyc);
        check("r_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("rdata", axi.rdata, mon_e.data);
          check("rid", axi.rid, mon_e.id);
          check("rresp", axi.rresp, mon_e.resp);
          check("rlast", axi.rlast, mon_e.last);
        end
      end
    end
  end

  task automatic model(input logic [IW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = int'(len) + 1;
    int wa = int'(addr[AW+1:2]);
    bit wrap = burst == 2'd2 && (n == 2 || n == 4 || n == 8 || n == 16);
    bit err = size != 3'd2 || burst == 2'd3 || (burst == 2'd2 && !wrap);
    for (int i = 0; i < n; i++) begin
      int a = burst == 2'd0 ? wa : wrap ? (wa / n) * n + (wa % n + i) % n : (wa + i) % (1 << AW);
      addr_q.push_back(a);
      exp_q.push_back(beat_t'{mem[a], id, err ? 2'b10 : 2'b00, i == n - 1});
    end
  endtask

  task automatic issue(input logic [IW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst, output int hs);
    int n = 0;
    model(id, addr, len, size, burst);
    {axi.arvalid, axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst} = {1'b1, id, addr, len, size, burst};
    hs = -1;
    while (hs < 0 && n < 200) begin
      @(negedge aclk);
      if (axi.arready) hs = cyc;
      n++;
    end
    @(posedge aclk);
    #1 axi.arvalid = 1'b0;
    check("ar_handshake", hs >= 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    check("drain_left", exp_q.size() + addr_q.size(), 0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  initial begin
    int t, n;
    logic [1:0] b;
    logic [3:0] ln;
    logic [2:0] sz;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    {axi.arvalid, axi.araddr, axi.arid, axi.arlen, axi.arsize, axi.arburst} = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_arready", axi.arready, 0);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_rlast", axi.rlast, 0);
    check("rst_rid", axi.rid, 0);
    check("rst_rresp", axi.rresp, 0);
    check("rst_ren", bram_ren, 0);
    check("rst_regen", bram_regen, 0);
    @(posedge aclk);
    #1 rst = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("arready_up", axi.arready, 1);
    @(posedge aclk);
    #1;
    first_ren = -1;
    first_rv = -1;
    issue(12'h001, 32'h10, 4'd3, 3'd2, 2'b01, t);
    drain();
    check("lat_ren", first_ren, t + 1);
    check("lat_rvalid", first_rv, t + 1 + L);
    issue(12'h002, 32'h18, 4'd3, 3'd2, 2'b10, t);
    issue(12'h003, 32'h08, 4'd2, 3'd2, 2'b00, t);
    drain();
    beat_cyc.delete();
    issue(12'h005, 32'h40, 4'd1, 3'd2, 2'b01, t);
    issue(12'h00A, 32'h80, 4'd1, 3'd2, 2'b01, t);
    drain();
    check("b2b_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) check("b2b_span", beat_cyc[3] - beat_cyc[0], 3);
    rr_val = 1'b0;
    repeat (2) @(posedge aclk);
    #1 ren_count = 0;
    issue(12'h007, 32'h100, 4'd15, 3'd2, 2'b01, t);
    repeat (20) @(posedge aclk);
    #1 check("stall_issues", ren_count, L + 2);
    rr_val = 1'b1;
    drain();
    issue(12'h003, 32'h200, 4'd2, 3'd1, 2'b01, t);
    issue(12'h004, 32'h300, 4'd1, 3'd2, 2'b01, t);
    drain();
    beats_seen = 0;
    issue(12'h009, 32'h40, 4'd7, 3'd2, 2'b01, t);
    n = 0;
    while (beats_seen == 0 && n < 50) begin
      @(posedge aclk);
      n++;
    end
    check("mid_first_beat", beats_seen, 1);
    #1 rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(negedge aclk);
    check("mid_rst_rvalid", axi.rvalid, 0);
    check("mid_rst_ren", bram_ren, 0);
    @(posedge aclk);
    #1 rst = 1'b0;
    @(posedge aclk);
    #1;
    issue(12'h077, 32'h400, 4'd3, 3'd2, 2'b01, t);
    drain();
    rr_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      b = 2'($urandom_range(0, 3));
      ln = (b == 2'd2 && $urandom_range(0, 3) != 0) ? 4'((2 << $urandom_range(0, 3)) - 1) : 4'($urandom_range(0, 15));
      sz = $urandom_range(0, 7) == 0 ? 3'($urandom_range(0, 7)) : 3'd2;
      issue(IW'($urandom), $urandom, ln, sz, b, t);
      repeat ($urandom_range(0, 2)) begin
        @(posedge aclk);
        #1;
      end
    end
    rr_rand = 1'b0;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axibram_read_wide.md
Name: axibram_read_wide

Overview:
Parametrised AXI3 read-slave bridge from a PS GP master port to a synchronous block RAM read port. It generalises data width, BRAM read latency and address-queue depth, and supports FIXED, INCR and WRAP bursts. Output is credit-flow-controlled through a small output FIFO, so BRAM data is never held stalled inside the RAM. Unsupported transfer sizes and reserved burst types return SLVERR.

Parameters:
DATA_BITS, 32, rdata/bram_rdata width; 32 or 64 only
ADDRESS_BITS, 10, BRAM word-address width
ID_BITS, 12, AXI ID width
AR_DEPTH_LOG2, 2, address FIFO depth = 2**AR_DEPTH_LOG2
BRAM_LATENCY, 2, BRAM read latency in cycles; 1 (no output register) or 2 (output register)

Ports:
aclk  in  1  clock; also drives bram_rclk
rst  in  1  reset, asynchronous, active-high
araddr  in  32  byte address
arvalid  in  1  AR valid
arready  out  1  AR ready = address FIFO not full
arid  in  ID_BITS  AR ID
arlen  in  4  beats-1
arsize  in  3  log2 bytes per beat
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
rdata  out  DATA_BITS  read data
rvalid  out  1  R valid
rready  in  1  R ready
rid  out  ID_BITS  R ID
rlast  out  1  last beat
rresp  out  2  00 OKAY, 10 SLVERR
bram_rclk  out  1  = aclk
bram_raddr  out  ADDRESS_BITS  BRAM word address
bram_ren  out  1  BRAM read enable
bram_regen  out  1  BRAM output register enable
bram_rdata  in  DATA_BITS  BRAM data

Behaviour:
- Reset: rst is asynchronous and active-high; clock is aclk. On reset, arready=0, rvalid=0, rlast=0, rresp=0, rid=0, bram_ren=0, bram_regen=0 and all FIFOs are empty. arready rises in the first cycle after rst deasserts.
- Reset mid-burst: all in-flight and queued transfers are discarded. No partial R beat appears after release.
- Address FIFO:
  - Written on arvalid&&arready.
  - Stores {arid, arburst, arsize, arlen, word address}.
  - Word address = araddr[ADDRESS_BITS+S-1:S], where S = log2(DATA_BITS/8). Higher address bits are ignored (aliasing).
- Burst engine states: IDLE, BURST.
  - IDLE -> BURST when the FIFO is non-empty. The entry is popped in the same cycle it is loaded.
  - BURST issues one bram_ren per cycle while credit is available. It decrements the beat counter on each issue.
  - On the last issue, BURST pops the next FIFO entry if one is present and stays in BURST (no bubble). Otherwise it returns to IDLE.
- Next-address rules:
  - FIXED: address unchanged.
  - INCR: +1, modulo 2**ADDRESS_BITS.
  - WRAP: low bits wrap on an (arlen+1)-beat boundary. arlen must be 1, 3, 7 or 15; any other arlen is treated as INCR and returns SLVERR.
  - Reserved burst type (11) is treated as INCR and returns SLVERR.
- Size check: if arsize != S, every beat of the burst returns rresp=SLVERR. Data is still read and the beat count is preserved.
- bram_raddr is valid whenever bram_ren=1. When bram_ren=0 it holds its last value.
- bram_regen:
  - BRAM_LATENCY=2: bram_regen equals bram_ren delayed by one cycle.
  - BRAM_LATENCY=1: bram_regen is constantly 0.
- Output FIFO (R_DEPTH = BRAM_LATENCY+2 entries):
  - Each entry holds {rid, rresp, rlast, rdata}.
  - It is written BRAM_LATENCY cycles after each bram_ren.
  - Issue requires (entries stored + reads in flight) < R_DEPTH. The BRAM pipeline is never stalled and data is never dropped.
- R handshake: rvalid = output FIFO non-empty. rdata, rid, rresp and rlast stay stable while rvalid&&!rready. A beat pops on rvalid&&rready.
- Latency: with everything idle and the AR handshake in cycle t, bram_ren is high in cycle t+1 and rvalid is high in cycle t+1+BRAM_LATENCY.
- Throughput: with rready held high, one beat per cycle, including across burst boundaries.
- Simultaneous push and pop on a full FIFO is allowed on both FIFOs. arready stays high when an AR write coincides with a pop on a full FIFO.

Decomposition:
- Package axibram_pkg holds:
  - burst codes BURST_FIXED, BURST_INCR, BURST_WRAP;
  - response codes RESP_OKAY, RESP_SLVERR;
  - the function computing the next word address from (addr, burst, len).
- One generic sub-module, fifo_sync_w_d (WIDTH, DEPTH_LOG2, with nempty/full/count outputs), is instantiated twice: once as the address FIFO and once as the output FIFO.

Test Plan:
- Default parameters, INCR, arlen=3, araddr=0x10, rready=1 -> bram_raddr 4,5,6,7 on consecutive cycles; rvalid first at t+3; rlast on beat 4 only; rresp=00.
- WRAP, arlen=3, araddr=0x18 -> bram_raddr 6,7,4,5; FIXED, arlen=2, araddr=0x8 -> bram_raddr 2,2,2.
- Two queued INCR bursts (arid 0x5 then 0xA, arlen=1), rready=1 -> four contiguous rvalid beats with rid 5,5,A,A and no gap.
- rready=0 for 20 cycles during a 16-beat burst -> bram_ren stops after 4 issues; no beat lost; data matches the BRAM model in order after rready=1.
- arsize=1 with DATA_BITS=32, arlen=2 -> 3 beats, all rresp=10, rlast on beat 3; a following legal burst returns OKAY.
- Assert rst in beat 2 of an 8-beat burst -> rvalid=0 immediately; after release, a new burst returns only its own beats.
